// File: rtl/seven_seg_scan_controller_if.sv
// rtl/seven_seg_scan_controller_if.sv - value source / decoder side signals of the digit scanner
interface seven_seg_scan_controller_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_WIDTH  = 16
);
  logic                    io_enable;
  logic                    io_load;
  logic [4*NUM_DIGITS-1:0] io_value;
  logic [DIV_WIDTH-1:0]    io_divisor;
  logic                    io_blankLeading;
  logic [6:0]              io_segIn;
  logic [3:0]              io_binOut;
  logic [6:0]              io_segOut;
  logic [NUM_DIGITS-1:0]   io_digitEn;
  logic                    io_frameDone;

  modport master (
    output io_enable, io_load, io_value, io_divisor, io_blankLeading, io_segIn,
    input  io_binOut, io_segOut, io_digitEn, io_frameDone
  );

  modport slave (
    input  io_enable, io_load, io_value, io_divisor, io_blankLeading, io_segIn,
    output io_binOut, io_segOut, io_digitEn, io_frameDone
  );
endinterface

// File: rtl/seven_seg_scan_controller.sv
// rtl/seven_seg_scan_controller.sv - multiplexed 7-seg digit scanner with guard blanking
module seven_seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int BLANK_CYCLES = 2
) (
  input logic                     clock,
  input logic                     reset,
  seven_seg_scan_controller_if.slave io
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
  localparam int CNT_W = (DIV_WIDTH > BLK_W) ? DIV_WIDTH : BLK_W;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [1:0]            state, state_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [VAL_W-1:0]      active, active_n;
  logic [VAL_W-1:0]      pending, pending_n;
  logic                  pend_valid, pend_valid_n;
  logic [NUM_DIGITS-1:0] digit_en, digit_en_n;
  logic                  frame_done;
  logic                  wrap;
  logic [CNT_W:0]        div_eff;
  logic [CNT_W:0]        cnt_inc;

  // Digit i (>0) is dark when it and every more significant nibble are zero.
  function automatic logic digit_blanked(input logic [VAL_W-1:0] val,
                                         input logic [IDX_W-1:0] i,
                                         input logic             bl);
    logic zeros;
    logic hit;
    zeros = 1'b1;
    hit   = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zeros = zeros & (val[4*k +: 4] == 4'h0);
      if (i == IDX_W'(k)) hit = zeros;
    end
    return bl & hit;
  endfunction

  assign div_eff = (io.io_divisor == '0) ? (CNT_W+1)'(1) : (CNT_W+1)'(io.io_divisor);
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    active_n     = active;
    pending_n    = pending;
    pend_valid_n = pend_valid;
    wrap         = 1'b0;
    digit_en_n   = '0;

    if (!io.io_enable) begin
      state_n = ST_IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_BLANK;
          idx_n   = '0;
          cnt_n   = '0;
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = ST_SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          // Compared against the live divisor so a shrink mid-slot ends it promptly.
          if (cnt_inc >= div_eff) begin
            state_n = ST_BLANK;
            cnt_n   = '0;
            if (idx == IDX_LAST) begin
              idx_n = '0;
              wrap  = 1'b1;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end

    if (wrap && pend_valid) begin
      active_n     = pending;
      pend_valid_n = 1'b0;
    end

    // The commit above uses the old pending, so a load on the wrap clock waits a frame.
    if (io.io_load) begin
      if (state == ST_IDLE) begin
        active_n  = io.io_value;
        pending_n = io.io_value;
      end else begin
        pending_n    = io.io_value;
        pend_valid_n = 1'b1;
      end
    end

    if (state_n == ST_SHOW && !digit_blanked(active_n, idx_n, io.io_blankLeading))
      digit_en_n = NUM_DIGITS'(1) << idx_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cnt        <= '0;
      active     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      active     <= active_n;
      pending    <= pending_n;
      pend_valid <= pend_valid_n;
      digit_en   <= digit_en_n;
      frame_done <= wrap;
    end
  end

  assign io.io_binOut    = active[{idx, 2'b00} +: 4];
  assign io.io_segOut    = (|digit_en) ? io.io_segIn : 7'h00;
  assign io.io_digitEn   = digit_en;
  assign io.io_frameDone = frame_done;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb/tb_seven_seg_scan_controller.sv - bench for seven_seg_scan_controller
module tb_seven_seg_scan_controller;
  localparam int ND = 4;
  localparam int DW = 16;
  localparam int BC = 2;

  logic clock = 1'b0;
  logic reset;

  seven_seg_scan_controller_if #(.NUM_DIGITS(ND), .DIV_WIDTH(DW)) bus ();

  seven_seg_scan_controller #(
    .NUM_DIGITS(ND), .DIV_WIDTH(DW), .BLANK_CYCLES(BC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference: one timer per slot, dark while t < BC, lit afterwards.
  bit          m_on;
  int          m_idx;
  int          m_t;
  logic [15:0] m_active;
  logic [15:0] m_pend;
  bit          m_pv;
  bit          m_fd;

  function automatic int eff_div(input logic [DW-1:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  function automatic logic [ND-1:0] exp_en();
    logic [15:0] upper;
    if (!m_on || m_t < BC) return '0;
    upper = m_active >> (4 * m_idx);
    if (m_idx > 0 && bus.io_blankLeading && upper == 16'h0) return '0;
    return ND'(1) << m_idx;
  endfunction

  task automatic model_step();
    bit was_on;
    bit wrap;
    was_on = m_on;
    wrap   = 1'b0;
    m_fd   = 1'b0;
    if (reset) begin
      m_on = 0; m_idx = 0; m_t = 0; m_active = '0; m_pend = '0; m_pv = 0;
    end else begin
      if (!bus.io_enable) begin
        m_on = 0; m_idx = 0; m_t = 0;
      end else if (!m_on) begin
        m_on = 1; m_idx = 0; m_t = 0;
      end else if (m_t < BC) begin
        m_t++;
      end else if (m_t - BC + 1 >= eff_div(bus.io_divisor)) begin
        wrap  = (m_idx == ND - 1);
        m_idx = (m_idx + 1) % ND;
        m_t   = 0;
      end else begin
        m_t++;
      end
      if (wrap) begin
        m_fd = 1'b1;
        if (m_pv) begin
          m_active = m_pend;
          m_pv     = 1'b0;
        end
      end
      if (bus.io_load) begin
        if (!was_on) begin
          m_active = bus.io_value;
          m_pend   = bus.io_value;
        end else begin
          m_pend = bus.io_value;
          m_pv   = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [ND-1:0] e;
    @(posedge clock);
    model_step();
    #1;
    e = exp_en();
    check("digit_en",   32'(bus.io_digitEn), 32'(e));
    check("seg_out",    32'(bus.io_segOut), (e != 0) ? 32'(bus.io_segIn) : 32'h0);
    check("bin_out",    32'(bus.io_binOut), 32'((m_active >> (4 * m_idx)) & 16'hF));
    check("frame_done", 32'(bus.io_frameDone), 32'(m_fd));
    bus.io_segIn = 7'($urandom);
  endtask

  task automatic load_value(input logic [15:0] v);
    bus.io_load  = 1'b1;
    bus.io_value = v;
    tick();
    bus.io_load  = 1'b0;
  endtask

  initial begin
    int first_on;
    int p_prev;
    int p_last;
    int np;
    bit found;

    reset               = 1'b1;
    bus.io_enable       = 1'b1;
    bus.io_load         = 1'b0;
    bus.io_value        = '0;
    bus.io_divisor      = 16'd3;
    bus.io_blankLeading = 1'b0;
    bus.io_segIn        = 7'h5a;

    // Reset held three clocks with enable high: everything dark.
    repeat (3) tick();
    reset = 1'b0;
    first_on = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (first_on < 0 && bus.io_digitEn != 0) first_on = i;
    end
    check("first_enable_clock", 32'(first_on), 32'(1 + BC));

    // Load in idle, then scan 1234 with divisor 3: 20-clock frames.
    bus.io_enable = 1'b0;
    tick();
    load_value(16'h1234);
    bus.io_enable = 1'b1;
    p_prev = 0; p_last = 0; np = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (bus.io_frameDone) begin p_prev = p_last; p_last = i; np++; end
    end
    check("frame_pulses_div3", 32'(np >= 2), 32'd1);
    check("frame_period_div3", 32'(p_last - p_prev), 32'd20);

    // Leading-zero blanking on 0042, then 0000.
    bus.io_blankLeading = 1'b1;
    load_value(16'h0042);
    repeat (50) tick();
    load_value(16'h0000);
    repeat (50) tick();
    bus.io_blankLeading = 1'b0;

    // No tearing: load during digit-1 show, then load exactly on the wrap clock.
    load_value(16'h1234);
    repeat (40) tick();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.io_digitEn == 4'b0010) found = 1;
    end
    check("wait_digit1", 32'(found), 32'd1);
    load_value(16'h5678);
    repeat (45) tick();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (m_on && m_idx == ND - 1 && m_t == BC + eff_div(bus.io_divisor) - 1) found = 1;
    end
    check("wait_wrap_clock", 32'(found), 32'd1);
    load_value(16'h9abc);
    check("wrap_load_done", 32'(bus.io_frameDone), 32'd1);
    repeat (45) tick();

    // Disable mid-show of digit 2, then restart.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.io_digitEn == 4'b0100) found = 1;
    end
    check("wait_digit2", 32'(found), 32'd1);
    bus.io_enable = 1'b0;
    tick();
    check("disable_digit_en", 32'(bus.io_digitEn), 32'h0);
    check("disable_no_frame", 32'(bus.io_frameDone), 32'h0);
    repeat (3) tick();
    bus.io_enable = 1'b1;
    repeat (30) tick();

    // Divisor 0 behaves as 1: 12-clock frames.
    bus.io_divisor = 16'd0;
    p_prev = 0; p_last = 0; np = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (bus.io_frameDone) begin p_prev = p_last; p_last = i; np++; end
    end
    check("frame_pulses_div0", 32'(np >= 2), 32'd1);
    check("frame_period_div0", 32'(p_last - p_prev), 32'd12);

    // Shrink divisor 8 -> 2 once the show counter has reached 5.
    bus.io_divisor = 16'd8;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (bus.io_digitEn != 0 && m_t - BC == 5) found = 1;
    end
    check("wait_cnt5", 32'(found), 32'd1);
    bus.io_divisor = 16'd2;
    tick();
    check("shrink_ends_slot", 32'(bus.io_digitEn), 32'h0);
    repeat (20) tick();

    // Randomised traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      bus.io_enable       = ($urandom_range(0, 99) < 95);
      bus.io_load         = ($urandom_range(0, 99) < 5);
      bus.io_value        = ($urandom_range(0, 3) == 0) ? 16'(4'($urandom)) : 16'($urandom);
      if ($urandom_range(0, 49) == 0) bus.io_divisor = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 99) == 0) bus.io_blankLeading = ~bus.io_blankLeading;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
